// File: rtl/mult_sequencer.sv
// ---------------------------------------------------------------------------
// mult_sequencer
//
// Control and register block for signed 8x8 shift-add multiplication using an
// external 9-bit ripple add/subtract unit. Holds multiplier B, accumulator
// X:A and latched multiplicand M, and walks eight ADD/SHIFT iterations.
// The 16-bit two's-complement product ends up in {A,B}, with X as its sign.
//
// Ports:
//   Clk           in   system clock, rising edge
//   Reset         in   synchronous active-high reset, clears all state
//   Run           in   level start request, sampled in IDLE
//   ClearA_LoadB  in   in IDLE: clear X:A, load B from Din (priority over Run)
//   Din     [7:0] in   switch operand input
//   add_x   [8:0] out  adder operand 1 = {A[7],A}
//   add_y   [8:0] out  adder operand 2 = {M[7],M}
//   add_fn        out  adder function: 0 = add, 1 = subtract (x - y)
//   add_s   [8:0] in   combinational adder result
//   Aval    [7:0] out  accumulator A (product high byte)
//   Bval    [7:0] out  B register (product low byte)
//   Xval          out  sign-extension bit X
//   busy          out  high in ADD/SHIFT
//   done          out  high in DONE
//
// Build option:
//   MULT_SKIP_ZERO_EN  when defined, an ADD step with B[0]=0 performs the
//                      shift in the same cycle (variable 9..17 cycle latency).
// ---------------------------------------------------------------------------
module mult_sequencer (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic       ClearA_LoadB,
    input  logic [7:0] Din,
    output logic [8:0] add_x,
    output logic [8:0] add_y,
    output logic       add_fn,
    input  logic [8:0] add_s,
    output logic [7:0] Aval,
    output logic [7:0] Bval,
    output logic       Xval,
    output logic       busy,
    output logic       done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ADD   = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0] r_state;
    logic       r_x;
    logic [7:0] r_a;
    logic [7:0] r_b;
    logic [7:0] r_m;
    logic [2:0] r_cnt;

    logic       w_last;
    logic [7:0] w_a_shift;
    logic [7:0] w_b_shift;

    // Arithmetic right shift of {X,A,B}: X is replicated into A[7], A[0]
    // falls into B[7], B[0] is consumed.
    assign w_last    = (r_cnt == 3'd7);
    assign w_a_shift = {r_x, r_a[7:1]};
    assign w_b_shift = {r_a[0], r_b[7:1]};

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_x     <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_m     <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (ClearA_LoadB) begin
                        r_x <= 1'b0;
                        r_a <= '0;
                        r_b <= Din;
                    end else if (Run) begin
                        r_x     <= 1'b0;
                        r_a     <= '0;
                        r_m     <= Din;
                        r_cnt   <= '0;
                        r_state <= S_ADD;
                    end
                end

                S_ADD: begin
`ifdef MULT_SKIP_ZERO_EN
                    if (r_b[0]) begin
                        {r_x, r_a} <= add_s;
                        r_state    <= S_SHIFT;
                    end else begin
                        // Nothing to add: fold this iteration's shift in here.
                        r_a <= w_a_shift;
                        r_b <= w_b_shift;
                        if (w_last) begin
                            r_state <= S_DONE;
                        end else begin
                            r_cnt   <= r_cnt + 3'd1;
                            r_state <= S_ADD;
                        end
                    end
`else
                    if (r_b[0]) begin
                        {r_x, r_a} <= add_s;
                    end
                    r_state <= S_SHIFT;
`endif
                end

                S_SHIFT: begin
                    r_a <= w_a_shift;
                    r_b <= w_b_shift;
                    if (w_last) begin
                        r_state <= S_DONE;
                    end else begin
                        r_cnt   <= r_cnt + 3'd1;
                        r_state <= S_ADD;
                    end
                end

                S_DONE: begin
                    if (!Run) begin
                        r_state <= S_IDLE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    // The last iteration weighs the multiplier's sign bit, so it subtracts.
    assign add_x  = {r_a[7], r_a};
    assign add_y  = {r_m[7], r_m};
    assign add_fn = (r_state == S_ADD) && w_last;

    assign Aval = r_a;
    assign Bval = r_b;
    assign Xval = r_x;
    assign busy = (r_state == S_ADD) || (r_state == S_SHIFT);
    assign done = (r_state == S_DONE);

endmodule

// File: tb/tb_mult_sequencer.sv
module tb_mult_sequencer;

    logic       Clk;
    logic       Reset;
    logic       Run;
    logic       ClearA_LoadB;
    logic [7:0] Din;
    logic [8:0] add_x;
    logic [8:0] add_y;
    logic       add_fn;
    logic [8:0] add_s;
    logic [7:0] Aval;
    logic [7:0] Bval;
    logic       Xval;
    logic       busy;
    logic       done;

    mult_sequencer dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Run          (Run),
        .ClearA_LoadB (ClearA_LoadB),
        .Din          (Din),
        .add_x        (add_x),
        .add_y        (add_y),
        .add_fn       (add_fn),
        .add_s        (add_s),
        .Aval         (Aval),
        .Bval         (Bval),
        .Xval         (Xval),
        .busy         (busy),
        .done         (done)
    );

    // External 9-bit ripple add/subtract unit.
    assign add_s = add_fn ? (add_x - add_y) : (add_x + add_y);

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_b_reg;

    typedef struct {
        logic [7:0] b;
        logic [7:0] m;
        logic [7:0] exp_a;
        logic [7:0] exp_b;
        logic       exp_x;
    } vec_t;

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] ref_prod(input logic [7:0] b, input logic [7:0] m);
        int p;
        p = int'($signed(b)) * int'($signed(m));
        return p[15:0];
    endfunction

    function automatic int ref_latency(input logic [7:0] b);
`ifdef MULT_SKIP_ZERO_EN
        return 9 + $countones(b);
`else
        return 17 + 0 * $countones(b);
`endif
    endfunction

    task automatic load_b(input logic [7:0] b);
        ClearA_LoadB = 1'b1;
        Din          = b;
        tick;
        ClearA_LoadB = 1'b0;
        Din          = 8'($urandom);
        exp_b_reg    = b;
    endtask

    task automatic mult(input logic [7:0] m, input bit pulse_clr, input string tag,
                        output logic [15:0] prod);
        int   ticks;
        int   fn_hits;
        bit   busy_ok;
        logic [15:0] p;
        p   = ref_prod(exp_b_reg, m);
        Run = 1'b1;
        Din = m;
        tick;
        check($sformatf("%s add_y", tag), 32'(add_y), 32'({m[7], m}));
        Din     = 8'($urandom);
        ticks   = 0;
        fn_hits = 0;
        busy_ok = 1'b1;
        while (done !== 1'b1 && ticks < 40) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (add_fn === 1'b1) fn_hits++;
            if (pulse_clr && ticks == 3) begin
                ClearA_LoadB = 1'b1;
                Din          = 8'hAA;
            end else begin
                ClearA_LoadB = 1'b0;
            end
            tick;
            ticks++;
        end
        ClearA_LoadB = 1'b0;
        check($sformatf("%s latency", tag), 32'(ticks + 1), 32'(ref_latency(exp_b_reg)));
        check($sformatf("%s busy_during", tag), 32'(busy_ok), 32'd1);
        check($sformatf("%s add_fn_hits", tag), 32'(fn_hits), 32'd1);
        check($sformatf("%s Aval", tag), 32'(Aval), 32'(p[15:8]));
        check($sformatf("%s Bval", tag), 32'(Bval), 32'(p[7:0]));
        check($sformatf("%s Xval", tag), 32'(Xval), 32'(p[15]));
        check($sformatf("%s busy_done", tag), 32'(busy), 32'd0);
        exp_b_reg = p[7:0];
        prod      = p;
    endtask

    task automatic leave_done(input string tag);
        Run = 1'b0;
        tick;
        check($sformatf("%s idle_done", tag), 32'(done), 32'd0);
        check($sformatf("%s idle_busy", tag), 32'(busy), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[8];
        logic [15:0] prod;

        vecs[0] = '{b: 8'hFD, m: 8'h07, exp_a: 8'hFF, exp_b: 8'hEB, exp_x: 1'b1};
        vecs[1] = '{b: 8'h80, m: 8'h80, exp_a: 8'h40, exp_b: 8'h00, exp_x: 1'b0};
        vecs[2] = '{b: 8'h00, m: 8'h5A, exp_a: 8'h00, exp_b: 8'h00, exp_x: 1'b0};
        vecs[3] = '{b: 8'h7F, m: 8'h7F, exp_a: 8'h3F, exp_b: 8'h01, exp_x: 1'b0};
        vecs[4] = '{b: 8'h80, m: 8'h7F, exp_a: 8'hC0, exp_b: 8'h80, exp_x: 1'b1};
        vecs[5] = '{b: 8'hFF, m: 8'hFF, exp_a: 8'h00, exp_b: 8'h01, exp_x: 1'b0};
        vecs[6] = '{b: 8'h01, m: 8'h80, exp_a: 8'hFF, exp_b: 8'h80, exp_x: 1'b1};
        vecs[7] = '{b: 8'h05, m: 8'hFD, exp_a: 8'hFF, exp_b: 8'hF1, exp_x: 1'b1};

        Reset        = 1'b1;
        Run          = 1'b0;
        ClearA_LoadB = 1'b0;
        Din          = 8'h00;
        exp_b_reg    = 8'h00;
        tick;
        tick;
        check("rst Aval", 32'(Aval), 32'd0);
        check("rst Bval", 32'(Bval), 32'd0);
        check("rst Xval", 32'(Xval), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst add_fn", 32'(add_fn), 32'd0);
        Reset = 1'b0;
        tick;

        // Directed vectors
        for (int i = 0; i < 8; i++) begin
            load_b(vecs[i].b);
            check($sformatf("vec%0d loadB", i), 32'(Bval), 32'(vecs[i].b));
            check($sformatf("vec%0d loadA", i), 32'(Aval), 32'd0);
            mult(vecs[i].m, 1'b0, $sformatf("vec%0d", i), prod);
            check($sformatf("vec%0d tabA", i), 32'(Aval), 32'(vecs[i].exp_a));
            check($sformatf("vec%0d tabB", i), 32'(Bval), 32'(vecs[i].exp_b));
            check($sformatf("vec%0d tabX", i), 32'(Xval), 32'(vecs[i].exp_x));
            leave_done($sformatf("vec%0d", i));
        end

        // Run and ClearA_LoadB together in IDLE: load wins, Run not recorded
        Run          = 1'b1;
        ClearA_LoadB = 1'b1;
        Din          = 8'h33;
        tick;
        Run          = 1'b0;
        ClearA_LoadB = 1'b0;
        check("both Bval", 32'(Bval), 32'h33);
        check("both Aval", 32'(Aval), 32'd0);
        check("both Xval", 32'(Xval), 32'd0);
        check("both busy", 32'(busy), 32'd0);
        tick;
        check("both stay_idle", 32'(busy), 32'd0);
        exp_b_reg = 8'h33;

        // ClearA_LoadB pulsed while busy must be ignored
        mult(8'hC5, 1'b1, "clr_busy", prod);
        leave_done("clr_busy");

        // Reset in the middle of a multiply
        load_b(8'h6B);
        Run = 1'b1;
        Din = 8'h95;
        tick;
        repeat (5) tick;
        Reset = 1'b1;
        tick;
        Reset = 1'b0;
        Run   = 1'b0;
        check("midrst Aval", 32'(Aval), 32'd0);
        check("midrst Bval", 32'(Bval), 32'd0);
        check("midrst Xval", 32'(Xval), 32'd0);
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst done", 32'(done), 32'd0);
        check("midrst add_y", 32'(add_y), 32'd0);
        exp_b_reg = 8'h00;
        tick;
        check("midrst idle", 32'(busy), 32'd0);
        load_b(8'h6B);
        mult(8'h95, 1'b0, "after_rst", prod);
        leave_done("after_rst");

        // Run held after DONE, then chained multiply on previous low byte
        load_b(8'h05);
        mult(8'hFD, 1'b0, "hold", prod);
        repeat (3) tick;
        check("hold done", 32'(done), 32'd1);
        check("hold Aval", 32'(Aval), 32'hFF);
        check("hold Bval", 32'(Bval), 32'hF1);
        check("hold busy", 32'(busy), 32'd0);
        leave_done("hold");
        mult(8'h0B, 1'b0, "chain", prod);
        check("chain prod", 32'({Aval, Bval}), 32'hFF5B);
        leave_done("chain");

        // Randomized operands against the arithmetic model
        for (int i = 0; i < 30; i++) begin
            logic [7:0] rb;
            logic [7:0] rm;
            bit         pc;
            rb = 8'($urandom);
            rm = 8'($urandom);
            pc = 1'($urandom_range(0, 1));
            load_b(rb);
            mult(rm, pc, $sformatf("rnd%0d", i), prod);
            leave_done($sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
